fwupd_rdout: RTL



---
 rtl/fwupd_pkg.sv | 8 +
 rtl/fwupd_rd_fifo.sv | 44 ++++
 rtl/fwupd_rdout.sv | 90 +++++++++
 3 files changed

// File: rtl/fwupd_pkg.sv
// fwupd_pkg: shared constants and types for the firmware-update URAM drain path.
package fwupd_pkg;
    localparam int FWUPD_BANK_WORDS = 128;
    localparam int FWUPD_ADDR_LOW   = $clog2(FWUPD_BANK_WORDS);
    localparam int FWUPD_ADDR_W     = FWUPD_ADDR_LOW + 1;
    typedef logic bank_t;
    typedef enum logic [1:0] {IDLE, READ, DRAIN, RELEASE} state_t;
endpackage

// File: rtl/fwupd_rd_fifo.sv
// fwupd_rd_fifo: synchronous FIFO with occupancy count; the head word is visible
// combinationally on dout_o while the FIFO is not empty.
module fwupd_rd_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0] cnt_q;
    logic full, wr, rd;
    assign full    = cnt_q == (AW + 1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
    assign wr      = push_i && (!full || pop_i);
    assign rd      = pop_i && !empty_o;
    assign dout_o  = mem_q[rptr_q];
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_q + AW'(wr);
            rptr_q <= rptr_q + AW'(rd);
            cnt_q  <= cnt_q + (AW + 1)'(wr) - (AW + 1)'(rd);
        end
    end
    always_ff @(posedge clk_i) begin
        if (wr) mem_q[wptr_q] <= din_i;
    end
    // Upstream credit accounting must make this unreachable.
    assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full && !pop_i))
        else $error("fwupd_rd_fifo: push while full");
endmodule

// File: rtl/fwupd_rdout.sv
// fwupd_rdout: drains full URAM ping-pong banks in strict alternation onto a
// valid/ready stream and hands each bank back once its last word is accepted.
module fwupd_rdout
    import fwupd_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_LOW   = FWUPD_ADDR_LOW,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [1:0]            bank_full_i,
    output logic [1:0]            bank_free_o,
    output logic                  ren_o,
    output logic [ADDR_LOW:0]     raddr_o,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic                  busy_o,
    output logic                  err_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    state_t state_q;
    bank_t cur_bank_q;
    logic [ADDR_LOW-1:0] word_q;
    logic [1:0] pending_q, pending_d, clr;
    logic err_q;
    logic [RD_LAT-1:0] pipe_v_q, pipe_l_q;
    logic [CW-1:0] fifo_cnt;
    logic fifo_empty;
    logic [DATA_WIDTH:0] fifo_head;
    int inflight;
    // Reads still in the URAM pipeline hold a FIFO slot, so a push can never overflow.
    assign inflight    = $countones(pipe_v_q);
    assign ren_o       = (state_q == READ) && (int'(fifo_cnt) + inflight < FIFO_DEPTH);
    assign raddr_o     = (state_q == READ) ? {cur_bank_q, word_q} : '0;
    assign clr         = (state_q == RELEASE) ? (2'b01 << cur_bank_q) : 2'b00;
    assign bank_free_o = clr;
    assign pending_d   = bank_full_i | (pending_q & ~clr);
    assign err_o       = err_q;
    assign busy_o      = (state_q != IDLE) || !fifo_empty;
    assign m_tvalid    = !fifo_empty;
    assign m_tdata     = fifo_empty ? '0 : fifo_head[DATA_WIDTH-1:0];
    assign m_tlast     = !fifo_empty && fifo_head[DATA_WIDTH];
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cur_bank_q <= '0;
            word_q     <= '0;
            pending_q  <= '0;
            err_q      <= 1'b0;
            pipe_v_q   <= '0;
            pipe_l_q   <= '0;
        end else begin
            pending_q <= pending_d;
            err_q     <= err_q | (|(bank_full_i & pending_q & ~clr));
            pipe_v_q  <= RD_LAT'({pipe_v_q, ren_o});
            pipe_l_q  <= RD_LAT'({pipe_l_q, ren_o && (&word_q)});
            case (state_q)
                IDLE: if (pending_q[cur_bank_q]) begin
                    state_q <= READ;
                    word_q  <= '0;
                end
                READ: if (ren_o) begin
                    word_q <= word_q + ADDR_LOW'(1);
                    if (&word_q) state_q <= DRAIN;
                end
                DRAIN: if (m_tvalid && m_tready && m_tlast) state_q <= RELEASE;
                RELEASE: begin
                    cur_bank_q <= ~cur_bank_q;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    fwupd_rd_fifo #(.WIDTH(DATA_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (pipe_v_q[RD_LAT-1]),
        .din_i   ({pipe_l_q[RD_LAT-1], rdata_i}),
        .pop_i   (m_tvalid && m_tready),
        .dout_o  (fifo_head),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );
endmodule
